data_mem_bridge: RTL and testbench
==================================

DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter DATA_W, default 32: data width; only 32 is supported.
REQ-002 Parameter NUM_REGIONS, default 2: number of memory regions; region 0 is user .data, region 1 is .kdata; legal range 1..4.
REQ-003 Parameter WAIT_STATES, default 1: extra memory cycles per access; legal range 0..7.
REQ-004 iCLK  input  1: single clock; all state updates on its rising edge.
REQ-005 iRST  input  1: reset, asynchronous, active-high.
REQ-006 iReq  input  1: core request; held with its fields until accepted.
REQ-007 iWe  input  1: 1 = store, 0 = load.
REQ-008 iSize  input  2: 0 = byte, 1 = half, 2 = word; 3 is illegal and treated as an error.
REQ-009 iUnsigned  input  1: zero-extend loads when 1, sign-extend when 0.
REQ-010 iAddr  input  32: byte address.
REQ-011 iWData  input  32: store data, right-justified.
REQ-012 oReady  output  1: request accepted on this edge when iReq is also 1.
REQ-013 oValid  output  1: one-cycle response strobe.
REQ-014 oRData  output  32: extended load data; valid while oValid is 1.
REQ-015 oErr  output  1: bus error flag; valid while oValid is 1.
REQ-016 oMemAddr  output  30: word address, iAddr[31:2].
REQ-017 oMemBE  output  4: byte lanes.
REQ-018 oMemWData  output  32: lane-replicated store data.
REQ-019 oMemWe  output  NUM_REGIONS: one write strobe per region.
REQ-020 iMemRData  input  NUM_REGIONS*32: synchronous region read ports, 1-cycle latency.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS and RESP; oReady SHALL be 1 only in IDLE.
REQ-022 On acceptance, address, size, write-enable, data and region index SHALL be registered; the state SHALL then be ACCESS, or RESP if an error is detected.
REQ-023 Region hit SHALL be BASE[i] <= iAddr <= LIMIT[i]; the lowest-index hit wins; no hit SHALL produce an error.
REQ-024 ACCESS SHALL last exactly WAIT_STATES+1 cycles, counted by a 3-bit down-counter.
REQ-025 oMemWe[region] SHALL pulse for the first ACCESS cycle only, and only for stores; all other oMemWe bits SHALL stay 0.
REQ-026 Load data SHALL be captured from the hit region's slice on the last ACCESS cycle.
REQ-027 RESP SHALL last one cycle with oValid=1, then return to IDLE; accept-to-oValid latency SHALL be WAIT_STATES+2 cycles, or 1 cycle on error.
REQ-028 Byte enables: byte = 1<<addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
REQ-029 Store data SHALL be replicated: byte into all 4 lanes, half into both halves.
REQ-030 Loads SHALL shift the selected lane to bit 0 and sign-extend or zero-extend per iUnsigned.
REQ-031 On error: oErr=1, oRData=0, and no oMemWe pulse.
REQ-032 For stores, oRData SHALL be 0 and oErr SHALL be 0 when no error is detected.

Reset
REQ-033 While iRST is 1, state SHALL be IDLE, and oValid, oErr, oMemWe and oMemBE SHALL be 0, oRData 0, and oReady 1.
REQ-034 Reset asserted mid-ACCESS SHALL abort the access immediately with no further write pulse and no response.

Configuration
REQ-035 Macro DMEM_ALIGN_CHECK_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL be an error.
REQ-036 DMEM_ALIGN_CHECK_EN undefined: offending low address bits SHALL be forced to 0 and the access SHALL proceed.

Structure
REQ-037 Package dmem_pkg SHALL hold the region BASE/LIMIT constant arrays, the size enum and the FSM state enum.
REQ-038 Sub-module dmem_lane_align SHALL be combinational and SHALL implement REQ-028 to REQ-030.

Verification
REQ-039 Word store 0xDEADBEEF to 0x10010004 (WAIT_STATES=1) -> one-cycle oMemWe=2'b01, BE=1111, oValid 3 cycles after accept, oErr=0.
REQ-040 Signed byte load at 0x10010007, memory word 0x80FF0000 -> oRData=0xFFFFFF80; with iUnsigned=1 -> 0x00000080.
REQ-041 Half store 0xABCD to 0x90000002 -> oMemWe=2'b10, BE=1100, oMemWData=0xABCDABCD.
REQ-042 Load from 0x00000000 (no region) -> oValid 1 cycle after accept, oErr=1, oRData=0, no strobes.
REQ-043 Word load at 0x10010002 -> with macro: oErr=1; without: reads word 0x10010000.
REQ-044 iRST pulsed during ACCESS of a store -> no second write pulse, no oValid, oReady=1 after release.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data memory bridge.
//   REGION_BASE / REGION_LIMIT : inclusive byte-address window of each region
//                                (0 = user .data, 1 = .kdata, 2 = global, 3 = stack)
//   accSizeT                   : access size encoding seen on iSize
//   bridgeStateT               : bridge FSM states
package dmem_pkg;

  localparam int MAX_REGIONS = 4;

  localparam logic [31:0] REGION_BASE [MAX_REGIONS] = '{
    32'h1001_0000, 32'h9000_0000, 32'h1000_0000, 32'h7FFF_0000
  };

  localparam logic [31:0] REGION_LIMIT [MAX_REGIONS] = '{
    32'h1001_FFFF, 32'h9000_FFFF, 32'h1000_FFFF, 32'h7FFF_FFFF
  };

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } accSizeT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bridgeStateT;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory bridge.
//   accSize    in  : access size (accSizeT)
//   addrLo     in  : byte offset within the word
//   isUnsigned in  : 1 = zero-extend loads, 0 = sign-extend
//   storeData  in  : right-justified store data
//   memWord    in  : raw word read from the selected region
//   byteEn     out : byte lane enables
//   wDataRep   out : store data replicated across lanes
//   loadData   out : selected lane shifted to bit 0 and extended
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  accSize,
  input  logic [1:0]  addrLo,
  input  logic        isUnsigned,
  input  logic [31:0] storeData,
  input  logic [31:0] memWord,
  output logic [3:0]  byteEn,
  output logic [31:0] wDataRep,
  output logic [31:0] loadData
);

  logic [31:0] shifted;

  assign shifted = memWord >> {addrLo, 3'b000};

  always_comb begin
    byteEn   = 4'b0000;
    wDataRep = storeData;
    loadData = 32'h0;
    case (accSizeT'(accSize))
      SZ_BYTE: begin
        byteEn   = 4'b0001 << addrLo;
        wDataRep = {4{storeData[7:0]}};
        loadData = isUnsigned ? {24'h0, shifted[7:0]}
                              : {{24{shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        byteEn   = 4'b0011 << addrLo;
        wDataRep = {2{storeData[15:0]}};
        loadData = isUnsigned ? {16'h0, shifted[15:0]}
                              : {{16{shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        byteEn   = 4'b1111;
        wDataRep = storeData;
        loadData = shifted;
      end
      default: begin
        byteEn   = 4'b0000;
        wDataRep = storeData;
        loadData = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// data_mem_bridge: bridges a core load/store request onto per-region
// synchronous memories with a fixed number of wait states.
//   iCLK, iRST           : clock, async active-high reset
//   iReq/oReady          : request handshake (accept when both 1)
//   iWe, iSize, iUnsigned, iAddr, iWData : request fields
//   oValid, oRData, oErr : one-cycle response
//   oMemAddr, oMemBE, oMemWData, oMemWe, iMemRData : region memory ports
// Build option: DMEM_ALIGN_CHECK_EN turns misaligned half/word accesses into
// errors; otherwise the offending low address bits are cleared.
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | memory access in flight, WAIT_STATES+1 cycles
// RESP   | oValid strobe, one cycle
module data_mem_bridge
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGIONS = 2,
  parameter int WAIT_STATES = 1
) (
  input  logic                          iCLK,
  input  logic                          iRST,
  input  logic                          iReq,
  input  logic                          iWe,
  input  logic [1:0]                    iSize,
  input  logic                          iUnsigned,
  input  logic [31:0]                   iAddr,
  input  logic [DATA_W-1:0]             iWData,
  output logic                          oReady,
  output logic                          oValid,
  output logic [DATA_W-1:0]             oRData,
  output logic                          oErr,
  output logic [29:0]                   oMemAddr,
  output logic [3:0]                    oMemBE,
  output logic [DATA_W-1:0]             oMemWData,
  output logic [NUM_REGIONS-1:0]        oMemWe,
  input  logic [NUM_REGIONS*DATA_W-1:0] iMemRData
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  bridgeStateT      state;
  logic [31:0]      addrR;
  logic [1:0]       sizeR;
  logic             weR;
  logic             unsR;
  logic [IDX_W-1:0] regionR;
  logic [2:0]       waitCnt;

  logic             hit;
  logic [IDX_W-1:0] hitIdx;
  logic             alignErr;
  logic             accErr;
  logic [31:0]      effAddr;
  logic [DATA_W-1:0] rWords [NUM_REGIONS];

  logic [1:0]       alSize;
  logic [1:0]       alAddr;
  logic [3:0]       alBe;
  logic [31:0]      alWData;
  logic [31:0]      alLoad;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : gRead
    assign rWords[g] = iMemRData[g*DATA_W +: DATA_W];
  end

  // Walk from the top so the lowest-index hit is the one left standing.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (iAddr >= REGION_BASE[i] && iAddr <= REGION_LIMIT[i]) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  assign alignErr = (iSize == SZ_HALF && iAddr[0]) ||
                    (iSize == SZ_WORD && iAddr[1:0] != 2'b00);
  assign effAddr  = iAddr;
`else
  assign alignErr = 1'b0;
  always_comb begin
    effAddr = iAddr;
    if (iSize == SZ_HALF) effAddr[0]   = 1'b0;
    if (iSize == SZ_WORD) effAddr[1:0] = 2'b00;
  end
`endif

  assign accErr = !hit || (iSize == SZ_BAD) || alignErr;

  // The lane aligner serves the incoming store in IDLE and the registered
  // load during ACCESS, so one instance covers both directions.
  assign alSize = (state == IDLE) ? iSize : sizeR;
  assign alAddr = (state == IDLE) ? effAddr[1:0] : addrR[1:0];

  dmem_lane_align uAlign (
    .accSize    (alSize),
    .addrLo     (alAddr),
    .isUnsigned (unsR),
    .storeData  (iWData[31:0]),
    .memWord    (rWords[regionR][31:0]),
    .byteEn     (alBe),
    .wDataRep   (alWData),
    .loadData   (alLoad)
  );

  // Present the address in the accept cycle so the read data is already
  // available in the first ACCESS cycle, then hold it for the write.
  assign oMemAddr = (state == IDLE) ? iAddr[31:2] : addrR[31:2];
  assign oReady   = (state == IDLE);

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      addrR     <= '0;
      sizeR     <= '0;
      weR       <= 1'b0;
      unsR      <= 1'b0;
      regionR   <= '0;
      waitCnt   <= '0;
      oValid    <= 1'b0;
      oErr      <= 1'b0;
      oRData    <= '0;
      oMemBE    <= '0;
      oMemWData <= '0;
      oMemWe    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iReq) begin
            addrR   <= effAddr;
            sizeR   <= iSize;
            weR     <= iWe;
            unsR    <= iUnsigned;
            regionR <= hitIdx;
            waitCnt <= 3'(WAIT_STATES);
            if (accErr) begin
              state  <= RESP;
              oValid <= 1'b1;
              oErr   <= 1'b1;
              oRData <= '0;
              oMemBE <= '0;
              oMemWe <= '0;
            end else begin
              state     <= ACCESS;
              oMemBE    <= alBe;
              oMemWData <= DATA_W'(alWData);
              oMemWe    <= iWe ? (NUM_REGIONS'(1) << hitIdx) : '0;
            end
          end
        end
        ACCESS: begin
          oMemWe <= '0;
          if (waitCnt == 3'd0) begin
            state  <= RESP;
            oValid <= 1'b1;
            oErr   <= 1'b0;
            oRData <= weR ? '0 : DATA_W'(alLoad);
            oMemBE <= '0;
          end else begin
            waitCnt <= waitCnt - 3'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          oValid <= 1'b0;
          oErr   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          oValid <= 1'b0;
          oErr   <= 1'b0;
          oMemWe <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb_data_mem_bridge: directed bench for data_mem_bridge (WAIT_STATES = 1,
// two regions) with a small byte-lane memory model behind each region.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'd0;
  logic        uns = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wData = 32'h0;
  logic        ready, valid, err;
  logic [31:0] rData;
  logic [29:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWData;
  logic [1:0]  memWe;
  logic [31:0] rd0 = 32'h0;
  logic [31:0] rd1 = 32'h0;

  logic [31:0] mem0 [16] = '{default: 32'h0};
  logic [31:0] mem1 [16] = '{default: 32'h0};

  int nCheck = 0;
  int nPass  = 0;

  int          wePulses = 0;
  logic [1:0]  lastWe = 2'b00;
  logic [3:0]  lastBe = 4'h0;
  logic [31:0] lastWd = 32'h0;

  int          lat;
  int          pulses;
  logic [31:0] gotR;
  logic        gotE;

  always #5 clk = ~clk;

  data_mem_bridge #(
    .DATA_W      (32),
    .NUM_REGIONS (2),
    .WAIT_STATES (1)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst),
    .iReq      (req),
    .iWe       (we),
    .iSize     (size),
    .iUnsigned (uns),
    .iAddr     (addr),
    .iWData    (wData),
    .oReady    (ready),
    .oValid    (valid),
    .oRData    (rData),
    .oErr      (err),
    .oMemAddr  (memAddr),
    .oMemBE    (memBe),
    .oMemWData (memWData),
    .oMemWe    (memWe),
    .iMemRData ({rd1, rd0})
  );

  // Region memories: synchronous read, byte-lane write, 16 words each.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (memWe[0] && memBe[b]) mem0[memAddr[3:0]][8*b +: 8] <= memWData[8*b +: 8];
      if (memWe[1] && memBe[b]) mem1[memAddr[3:0]][8*b +: 8] <= memWData[8*b +: 8];
    end
    rd0 <= mem0[memAddr[3:0]];
    rd1 <= mem1[memAddr[3:0]];
  end

  always @(negedge clk) begin
    if (memWe != 2'b00) begin
      wePulses = wePulses + 1;
      lastWe   = memWe;
      lastBe   = memBe;
      lastWd   = memWData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCheck++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issues one request and waits (bounded) for its response.
  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int p0;
    @(negedge clk);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wData = d;
    p0 = wePulses;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0; gotR = 32'hx; gotE = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (valid) begin
        lat = k; gotR = rData; gotE = err;
        break;
      end
    end
    pulses = wePulses - p0;
  endtask

  initial begin
    int p0;
    bit sawValid;

    // reset state
    #3;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err",   32'(err),   32'd0);
    chk("rst_we",    32'(memWe), 32'd0);
    chk("rst_be",    32'(memBe), 32'd0);
    chk("rst_rdata", rData,      32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // word store DEADBEEF
    access(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'hDEAD_BEEF);
    chk("sw_lat",    32'(lat),    32'd3);
    chk("sw_err",    32'(gotE),   32'd0);
    chk("sw_rdata",  gotR,        32'h0);
    chk("sw_pulses", 32'(pulses), 32'd1);
    chk("sw_we",     32'(lastWe), 32'b01);
    chk("sw_be",     32'(lastBe), 32'hF);
    chk("sw_wd",     lastWd,      32'hDEAD_BEEF);

    access(1'b0, 2'd2, 1'b0, 32'h1001_0004, 32'h0);
    chk("lw_data",   gotR,        32'hDEAD_BEEF);
    chk("lw_lat",    32'(lat),    32'd3);
    chk("lw_pulses", 32'(pulses), 32'd0);

    // byte / half loads with extension
    access(1'b1, 2'd2, 1'b0, 32'h1001_0004, 32'h80FF_0000);
    access(1'b0, 2'd0, 1'b0, 32'h1001_0007, 32'h0);
    chk("lb_s7", gotR, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b1, 32'h1001_0007, 32'h0);
    chk("lb_u7", gotR, 32'h0000_0080);
    access(1'b0, 2'd0, 1'b0, 32'h1001_0006, 32'h0);
    chk("lb_s6", gotR, 32'hFFFF_FFFF);
    access(1'b0, 2'd0, 1'b1, 32'h1001_0006, 32'h0);
    chk("lb_u6", gotR, 32'h0000_00FF);
    access(1'b0, 2'd0, 1'b0, 32'h1001_0005, 32'h0);
    chk("lb_s5", gotR, 32'h0000_0000);
    access(1'b0, 2'd1, 1'b0, 32'h1001_0006, 32'h0);
    chk("lh_s6", gotR, 32'hFFFF_80FF);

    // half store into .kdata
    access(1'b1, 2'd1, 1'b0, 32'h9000_0002, 32'h0000_ABCD);
    chk("sh_pulses", 32'(pulses), 32'd1);
    chk("sh_we",     32'(lastWe), 32'b10);
    chk("sh_be",     32'(lastBe), 32'hC);
    chk("sh_wd",     lastWd,      32'hABCD_ABCD);
    access(1'b0, 2'd2, 1'b0, 32'h9000_0000, 32'h0);
    chk("kw_data", gotR, 32'hABCD_0000);
    access(1'b0, 2'd1, 1'b1, 32'h9000_0002, 32'h0);
    chk("kh_u", gotR, 32'h0000_ABCD);
    access(1'b0, 2'd1, 1'b0, 32'h9000_0002, 32'h0);
    chk("kh_s", gotR, 32'hFFFF_ABCD);

    // byte store replicated into a single lane
    access(1'b1, 2'd0, 1'b0, 32'h9000_0001, 32'h0000_0012);
    chk("sb_be", 32'(lastBe), 32'h2);
    chk("sb_wd", lastWd,      32'h1212_1212);
    access(1'b0, 2'd2, 1'b0, 32'h9000_0000, 32'h0);
    chk("kw2_data", gotR, 32'hABCD_1200);

    // unmapped address
    access(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0);
    chk("nr_lat",    32'(lat),    32'd1);
    chk("nr_err",    32'(gotE),   32'd1);
    chk("nr_rdata",  gotR,        32'h0);
    chk("nr_pulses", 32'(pulses), 32'd0);
    access(1'b1, 2'd2, 1'b0, 32'h1002_0000, 32'h5555_5555);
    chk("nrs_err",    32'(gotE),   32'd1);
    chk("nrs_pulses", 32'(pulses), 32'd0);

    // region limit is inclusive
    access(1'b0, 2'd0, 1'b1, 32'h1001_FFFF, 32'h0);
    chk("lim_err", 32'(gotE), 32'd0);
    chk("lim_lat", 32'(lat),  32'd3);
    access(1'b0, 2'd0, 1'b1, 32'h1000_FFFF, 32'h0);
    chk("below_err", 32'(gotE), 32'd1);

    // illegal size
    access(1'b0, 2'd3, 1'b0, 32'h1001_0000, 32'h0);
    chk("sz3_err", 32'(gotE), 32'd1);
    chk("sz3_lat", 32'(lat),  32'd1);

    // misaligned word load
    access(1'b1, 2'd2, 1'b0, 32'h1001_0000, 32'h1234_5678);
    access(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    chk("mis_err", 32'(gotE), 32'd1);
    chk("mis_rd",  gotR,      32'h0);
`else
    chk("mis_err", 32'(gotE), 32'd0);
    chk("mis_rd",  gotR,      32'h1234_5678);
`endif

    // reset during the ACCESS of a store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h1001_0008; wData = 32'h1111_1111;
    p0 = wePulses;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mr_ready_in_rst", 32'(ready), 32'd1);
    chk("mr_we_in_rst",    32'(memWe), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sawValid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (valid) sawValid = 1'b1;
    end
    chk("mr_pulses", 32'(wePulses - p0), 32'd1);
    chk("mr_novalid", 32'(sawValid),     32'd0);
    chk("mr_ready",   32'(ready),        32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0);
    chk("mr_after", gotR, 32'h1111_1111);

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
